mult44_arbiter: RTL
===================

Name: mult44_arbiter

Overview:
- Shares one 44x44 unsigned multiplier datapath among NREQ requesters.
- Round-robin arbitration, one accepted operation per cycle.
- Fixed-latency pipeline carries the requester ID and a valid bit alongside the product.
- Sits between the FPU issue logic (several mantissa-multiply clients) and the single mult44x44comb instance, which is instantiated inside this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 4, cycles from accept to o_vld (min 2); stage 1 registers operands, multiplier is combinational between stages 1 and 2, stages 3..LAT are delay registers.
- IDW, 3, width of the result ID field; must hold NREQ-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active low.
- ce  in  1  pipeline clock enable; when low, all pipeline and arbiter state holds.
- flush  in  1  synchronous kill of all in-flight operations.
- req  in  NREQ  per-requester request.
- a  in  NREQ*44  operand A, packed, requester i at [44*i+43:44*i].
- b  in  NREQ*44  operand B, packed the same way.
- ack  out  NREQ  one-hot accept; the requester may drop or change operands next cycle.
- o_vld  out  1  product valid.
- o_id  out  IDW  requester index of the product.
- o  out  88  product.
- busy  out  1  any operation in flight.
- inflight  out  $clog2(LAT+1)  count of valid pipeline stages.

Behaviour:
- Reset is one clock; reset is asynchronous and active-low: rst_n low clears all state immediately, independent of clk. Reset values:
  - ack=0, o_vld=0, o_id=0, o=0, busy=0, inflight=0.
  - Round-robin pointer=0; all pipeline valid bits=0.
- ack is combinational from req, the pointer, ce and flush:
  - Grant the first requester with req set, searching circularly from the pointer.
  - ack=0 when ce=0, flush=1 or req=0.
  - At most one ack bit set per cycle.
- On a clk edge with ack[i]=1:
  - Capture a[i] and b[i] into stage 1, with valid=1 and id=i.
  - Pointer becomes (i+1) mod NREQ.
  - With no grant, the pointer is unchanged and stage 1 valid=0.
- Each ce=1 cycle, valid, id and data advance one stage.
- o_vld, o_id and o are the stage-LAT registers.
- Latency: ack high at edge T gives o_vld high for exactly the cycle after edge T+LAT-1, i.e. LAT edges after capture. With continuous ce, throughput is 1 per cycle.
- ce=0: everything holds, including o_vld. A held o_vld is the same result and must not be counted twice; downstream qualifies it with ce.
- flush=1 with ce=1: all valid bits, including the output stage, clear at the edge; no capture that cycle; data registers are don't-care. flush with ce=0 still clears valids.
- There is no result backpressure; consumers must always sink o_vld.
- inflight counts the valid bits over stages 1..LAT, registered. busy = (inflight != 0).
- Starvation bound: a requester holding req continuously receives ack within NREQ cycles of ce=1.
- A requester that drops req before ack loses nothing; no state is kept for it.
- rst_n asserted mid-operation discards all in-flight results; no o_vld follows after release.
- Product: o = a*b exactly, 88 bits, no truncation. Operands 0, and all-ones times all-ones (gives 88'hFFFFFFFFFFE00000000001), must be exact.

Optional Feature:
- Macro: MULT44_ARB_SIGNED_EN.
- When defined:
  - Adds input port sgn, NREQ bits, per requester.
  - Operands of a requester with sgn[i]=1 are 44-bit two's complement.
  - Stage 1 stores the magnitudes plus sign = a[43]^b[43].
  - The magnitude product is negated to 88-bit two's complement in the final stage.
  - Latency is unchanged.
- When undefined: no sgn port; all operands are unsigned.

Test Plan:
- Single op: req=4'b0001, a0=44'd3, b0=44'd5 -> ack=0001, LAT cycles later o_vld=1, o_id=0, o=88'd15, busy=0 the cycle after.
- All four requesting continuously, pointer=0 -> ack sequence 0001,0010,0100,1000,0001, o_id sequence 0,1,2,3,0, one result per cycle.
- Max operands: a=b=44'hFFFFFFFFFFF -> o=88'hFFFFFFFFFFE00000000001.
- ce low for 3 cycles with 2 ops in flight -> outputs frozen; both results appear after ce returns, total delay LAT+3.
- flush with 3 ops in flight -> inflight=0 and o_vld=0 next cycle; no stale o_vld ever appears.
- rst_n pulsed low asynchronously mid-stream -> o_vld drops immediately; pointer=0; no results after release. With MULT44_ARB_SIGNED_EN: sgn=1, a=-3, b=7 -> o=-21 in 88 bits.

Source files
------------

// File: rtl/mult44_arbiter.sv
// mult44_arbiter
// ---------------------------------------------------------------------------
// Shares one 44x44 unsigned multiplier among NREQ requesters. A round-robin
// arbiter accepts at most one operation per cycle. A fixed-latency pipeline
// carries a valid bit and the requester ID alongside the product.
//
// Pipeline stages:
//   stage 1        registered operands (and sign when signed mode is built)
//   stage 2        registered output of the combinational multiplier
//   stages 3..LAT  delay registers; the final stage drives the outputs
//
// Optional feature macro: MULT44_ARB_SIGNED_EN
//   When defined, adds port sgn[NREQ-1:0]. A requester with sgn[i]=1 supplies
//   44-bit two's complement operands. Magnitudes are multiplied and the
//   result is negated on entry to the final stage. Latency is unchanged.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   LAT   cycles from accept to o_vld (>= 2)
//   IDW   width of the requester ID field (must hold NREQ-1)
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset
//   ce        pipeline clock enable; low holds all pipeline and arbiter state
//   flush     synchronous kill of every in-flight operation
//   req       per-requester request
//   sgn       per-requester signed-operand select (signed build only)
//   a, b      packed operands, requester i at [44*i+43:44*i]
//   ack       one-hot accept, combinational
//   o_vld     product valid (final pipeline stage)
//   o_id      requester index of the product
//   o         88-bit product
//   busy      any operation in flight
//   inflight  number of valid pipeline stages
// ---------------------------------------------------------------------------

// Purely combinational 44x44 unsigned multiplier shared by all requesters.
module mult44x44comb (
    input  logic [43:0] i_a,
    input  logic [43:0] i_b,
    output logic [87:0] o_p
);
    assign o_p = {44'd0, i_a} * {44'd0, i_b};
endmodule

module mult44_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 4,
    parameter int IDW  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     flush,
    input  logic [NREQ-1:0]          req,
`ifdef MULT44_ARB_SIGNED_EN
    input  logic [NREQ-1:0]          sgn,
`endif
    input  logic [NREQ*44-1:0]       a,
    input  logic [NREQ*44-1:0]       b,
    output logic [NREQ-1:0]          ack,
    output logic                     o_vld,
    output logic [IDW-1:0]           o_id,
    output logic [87:0]              o,
    output logic                     busy,
    output logic [$clog2(LAT+1)-1:0] inflight
);

    localparam int CW = $clog2(LAT+1);

    logic [IDW-1:0] r_ptr;
    logic [LAT:1]   r_vld;
    logic [IDW-1:0] r_id   [1:LAT];
    logic [43:0]    r_a1;
    logic [43:0]    r_b1;
    logic [87:0]    r_prod [2:LAT];
    logic [CW-1:0]  r_inflight;

    logic           w_grantVld;
    logic [IDW-1:0] w_grantIdx;
    logic           w_accept;
    logic [IDW-1:0] w_nextPtr;
    logic [43:0]    w_selA;
    logic [43:0]    w_selB;
    logic [43:0]    w_capA;
    logic [43:0]    w_capB;
    logic [LAT:1]   w_vldNext;
    logic [CW-1:0]  w_cnt;
    logic [87:0]    w_mult;
    logic [87:0]    w_stageIn [2:LAT];
    logic [87:0]    w_final;

    // Circular search starting at the pointer; the first requester found wins.
    always_comb begin : arbSearch
        int cand;
        cand       = 0;
        w_grantVld = 1'b0;
        w_grantIdx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(r_ptr) + k) % NREQ;
            if (!w_grantVld && req[cand]) begin
                w_grantVld = 1'b1;
                w_grantIdx = IDW'(cand);
            end
        end
    end

    // A grant only becomes an accept when the pipeline is moving and not
    // being flushed, so ack never promises a capture that will not happen.
    assign w_accept  = ce & ~flush & w_grantVld;
    assign ack       = w_accept ? (NREQ'(1) << w_grantIdx) : '0;
    assign w_nextPtr = IDW'((int'(w_grantIdx) + 1) % NREQ);

    assign w_selA = a[44*w_grantIdx +: 44];
    assign w_selB = b[44*w_grantIdx +: 44];

`ifdef MULT44_ARB_SIGNED_EN
    logic         w_negA;
    logic         w_negB;
    logic         w_capSgn;
    logic [LAT-1:1] r_sgn;

    // Signed operands are reduced to magnitudes; -2^43 maps to 2^43, which
    // still fits in 44 unsigned bits.
    assign w_negA   = sgn[w_grantIdx] & w_selA[43];
    assign w_negB   = sgn[w_grantIdx] & w_selB[43];
    assign w_capA   = w_negA ? (~w_selA + 44'd1) : w_selA;
    assign w_capB   = w_negB ? (~w_selB + 44'd1) : w_selB;
    assign w_capSgn = w_negA ^ w_negB;
`else
    assign w_capA = w_selA;
    assign w_capB = w_selB;
`endif

    mult44x44comb u_mult (
        .i_a (r_a1),
        .i_b (r_b1),
        .o_p (w_mult)
    );

    // Inputs to each product stage: stage 2 takes the multiplier, later
    // stages take the previous stage.
    always_comb begin : productPath
        w_stageIn[2] = w_mult;
        for (int k = 3; k <= LAT; k++) begin
            w_stageIn[k] = r_prod[k-1];
        end
    end

`ifdef MULT44_ARB_SIGNED_EN
    assign w_final = r_sgn[LAT-1] ? (~w_stageIn[LAT] + 88'd1) : w_stageIn[LAT];
`else
    assign w_final = w_stageIn[LAT];
`endif

    // Flush wins over ce so that a stalled pipeline can still be killed.
    always_comb begin : validNext
        w_vldNext = r_vld;
        if (flush) begin
            w_vldNext = '0;
        end else if (ce) begin
            w_vldNext = {r_vld[LAT-1:1], w_grantVld};
        end
    end

    assign w_cnt = CW'($countones(w_vldNext));

    // Arbiter pointer, valid/ID pipeline and product pipeline. The occupancy
    // count is registered from the next-state valid vector so it always
    // matches the valid bits it describes.
    always_ff @(posedge clk or negedge rst_n) begin : pipeRegs
        if (!rst_n) begin
            r_ptr      <= '0;
            r_vld      <= '0;
            r_inflight <= '0;
            r_a1       <= '0;
            r_b1       <= '0;
            for (int k = 1; k <= LAT; k++) begin
                r_id[k] <= '0;
            end
            for (int k = 2; k <= LAT; k++) begin
                r_prod[k] <= '0;
            end
`ifdef MULT44_ARB_SIGNED_EN
            r_sgn <= '0;
`endif
        end else begin
            r_vld      <= w_vldNext;
            r_inflight <= w_cnt;
            if (w_accept) begin
                r_ptr   <= w_nextPtr;
                r_a1    <= w_capA;
                r_b1    <= w_capB;
                r_id[1] <= w_grantIdx;
`ifdef MULT44_ARB_SIGNED_EN
                r_sgn[1] <= w_capSgn;
`endif
            end
            if (ce) begin
                for (int k = 2; k <= LAT; k++) begin
                    r_id[k] <= r_id[k-1];
                end
                for (int k = 2; k < LAT; k++) begin
                    r_prod[k] <= w_stageIn[k];
                end
                r_prod[LAT] <= w_final;
`ifdef MULT44_ARB_SIGNED_EN
                for (int k = 2; k < LAT; k++) begin
                    r_sgn[k] <= r_sgn[k-1];
                end
`endif
            end
        end
    end

    assign o_vld    = r_vld[LAT];
    assign o_id     = r_id[LAT];
    assign o        = r_prod[LAT];
    assign inflight = r_inflight;
    assign busy     = (r_inflight != '0);

endmodule
